// File: rtl/simplerisc_pkg.sv
// Shared definitions for the simplerisc pipeline: default datapath width, register index
// width and the data-memory stage FSM states.
package simplerisc_pkg;

   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned REG_W          = 5;

   typedef enum logic {
      StIdle,
      StBusy
   } dm_state_t;

endpackage

// File: rtl/dm_mem_stage.sv
// Memory-access stage: req/ack handshake with data memory, front-end stall, DM->RW register.
// Optional DM_TIMEOUT_EN aborts an access after TIMEOUT unacknowledged BUSY cycles.
module dm_mem_stage
   import simplerisc_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEFAULT,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] aluResult_DM,
   input  logic [DATA_W-1:0] op2_DM,
   input  logic [REG_W-1:0]  rd_DM,
   input  logic              isWb_DM,
   input  logic              isLd_DM,
   input  logic              isSt_DM,
   input  logic              valid_DM,
   output logic              stall_DM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ldResult_RW,
   output logic [DATA_W-1:0] aluResult_RW,
   output logic [REG_W-1:0]  rd_RW,
   output logic              isWb_RW,
   output logic              isLd_RW,
   output logic              valid_RW,
   output logic              memErr_RW
);

   dm_state_t state_q, state_d;
   logic      memop;
   logic      busy;
   logic      abort;

   assign memop = valid_DM & (isLd_DM | isSt_DM);
   assign busy  = (state_q == StBusy);

`ifdef DM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q;

   // Held at zero while idle, so it is already clear on entry to BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!busy) begin
         cnt_q <= '0;
      end else if (!mem_ack) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // An ack in the final allowed cycle takes priority over the abort.
   assign abort = busy & ~mem_ack & (cnt_q == CntW'(TIMEOUT - 1));
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      stall_DM = 1'b0;
      unique case (state_q)
         StIdle: begin
            stall_DM = memop;
            if (memop) state_d = StBusy;
         end
         StBusy: begin
            stall_DM = ~mem_ack & ~abort;
            if (mem_ack || abort) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state_q <= state_d;
         mem_req <= (state_d == StBusy);
         if (!busy && memop) begin
            mem_we    <= isSt_DM;
            mem_addr  <= aluResult_DM;
            mem_wdata <= op2_DM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ldResult_RW  <= '0;
         aluResult_RW <= '0;
         rd_RW        <= '0;
         isWb_RW      <= 1'b0;
         isLd_RW      <= 1'b0;
         valid_RW     <= 1'b0;
         memErr_RW    <= 1'b0;
      end else if (stall_DM) begin
         valid_RW  <= 1'b0;
         isWb_RW   <= 1'b0;
         memErr_RW <= 1'b0;
      end else begin
         aluResult_RW <= aluResult_DM;
         rd_RW        <= rd_DM;
         isWb_RW      <= isWb_DM & ~abort;
         isLd_RW      <= isLd_DM;
         valid_RW     <= valid_DM | abort;
         memErr_RW    <= abort;
         // mem_we distinguishes the outstanding access; ld+st together is a store.
         if (busy && mem_ack && !mem_we) ldResult_RW <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dm_mem_stage.sv
// Directed bench for dm_mem_stage: RW-register scoreboard plus per-cycle handshake checks.
// Build with DM_TIMEOUT_EN defined to also exercise the timeout abort (TIMEOUT = 4).
module tb_dm_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] aluResult_DM, op2_DM;
   logic [4:0]  rd_DM;
   logic        isWb_DM, isLd_DM, isSt_DM, valid_DM;
   logic        stall_DM, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] ldResult_RW, aluResult_RW;
   logic [4:0]  rd_RW;
   logic        isWb_RW, isLd_RW, valid_RW, memErr_RW;

   typedef struct {
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        wb;
      logic        ld;
      logic [31:0] ldres;
      logic        err;
   } rw_t;

   rw_t         sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_ld = '0;

   dm_mem_stage #(.DATA_W(32), .TIMEOUT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .aluResult_DM (aluResult_DM),
      .op2_DM       (op2_DM),
      .rd_DM        (rd_DM),
      .isWb_DM      (isWb_DM),
      .isLd_DM      (isLd_DM),
      .isSt_DM      (isSt_DM),
      .valid_DM     (valid_DM),
      .stall_DM     (stall_DM),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .ldResult_RW  (ldResult_RW),
      .aluResult_RW (aluResult_RW),
      .rd_RW        (rd_RW),
      .isWb_RW      (isWb_RW),
      .isLd_RW      (isLd_RW),
      .valid_RW     (valid_RW),
      .memErr_RW    (memErr_RW)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic ld, input logic st, input logic wb,
                        input logic [31:0] alu, input logic [31:0] op2, input logic [4:0] rd);
      valid_DM     = v;
      isLd_DM      = ld;
      isSt_DM      = st;
      isWb_DM      = wb;
      aluResult_DM = alu;
      op2_DM       = op2;
      rd_DM        = rd;
   endtask

   task automatic expect_rw(input logic [31:0] alu, input logic [4:0] rd, input logic wb,
                            input logic ld, input logic [31:0] ldres, input logic err);
      rw_t e;
      e.alu   = alu;
      e.rd    = rd;
      e.wb    = wb;
      e.ld    = ld;
      e.ldres = ldres;
      e.err   = err;
      sb.push_back(e);
   endtask

   // Every valid RW slot must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_RW === 1'b1) begin
         if (sb.size() == 0) begin
            chk("rw_unexpected", 64'(valid_RW), 64'd0);
         end else begin
            rw_t e;
            e = sb.pop_front();
            chk("rw_alu", 64'(aluResult_RW), 64'(e.alu));
            chk("rw_rd", 64'(rd_RW), 64'(e.rd));
            chk("rw_wb", 64'(isWb_RW), 64'(e.wb));
            chk("rw_ld", 64'(isLd_RW), 64'(e.ld));
            chk("rw_ldres", 64'(ldResult_RW), 64'(e.ldres));
            chk("rw_err", 64'(memErr_RW), 64'(e.err));
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      repeat (2) step();
      chk("rst_stall", 64'(stall_DM), 64'd0);
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_valid", 64'(valid_RW), 64'd0);
      chk("rst_alu", 64'(aluResult_RW), 64'd0);
      chk("rst_ldres", 64'(ldResult_RW), 64'd0);
      chk("rst_rd", 64'(rd_RW), 64'd0);
      chk("rst_wb", 64'(isWb_RW), 64'd0);
      chk("rst_isld", 64'(isLd_RW), 64'd0);
      chk("rst_err", 64'(memErr_RW), 64'd0);
      rst_n = 1'b1;
      step();

      // ALU pass-through
      drive(1, 0, 0, 1, 32'h1234, 32'h0, 5'd3);
      #1 chk("alu_stall", 64'(stall_DM), 64'd0);
      expect_rw(32'h1234, 5'd3, 1'b1, 1'b0, exp_ld, 1'b0);
      step();
      chk("alu_req", 64'(mem_req), 64'd0);
      chk("alu_valid", 64'(valid_RW), 64'd1);
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

      // Load, ack three cycles after mem_req rises
      step();
      drive(1, 1, 0, 1, 32'h40, 32'h0, 5'd5);
      #1 chk("ld_stall0", 64'(stall_DM), 64'd1);
      chk("ld_req0", 64'(mem_req), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ld_req", 64'(mem_req), 64'd1);
         chk("ld_addr", 64'(mem_addr), 64'h40);
         chk("ld_we", 64'(mem_we), 64'd0);
         chk("ld_stall", 64'(stall_DM), 64'd1);
         chk("ld_bubble", 64'(valid_RW), 64'd0);
      end
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      #1 chk("ld_ack_stall", 64'(stall_DM), 64'd0);
      chk("ld_ack_req", 64'(mem_req), 64'd1);
      exp_ld = 32'hDEADBEEF;
      expect_rw(32'h40, 5'd5, 1'b1, 1'b1, exp_ld, 1'b0);
      step();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("ld_done_req", 64'(mem_req), 64'd0);
      chk("ld_result", 64'(ldResult_RW), 64'hDEADBEEF);
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

      // Store, ack in the first request cycle
      step();
      drive(1, 0, 1, 0, 32'h80, 32'hA5A5, 5'd7);
      #1 chk("st_stall0", 64'(stall_DM), 64'd1);
      step();
      chk("st_req", 64'(mem_req), 64'd1);
      chk("st_we", 64'(mem_we), 64'd1);
      chk("st_addr", 64'(mem_addr), 64'h80);
      chk("st_wdata", 64'(mem_wdata), 64'hA5A5);
      mem_ack = 1'b1;
      #1 chk("st_ack_stall", 64'(stall_DM), 64'd0);
      expect_rw(32'h80, 5'd7, 1'b0, 1'b0, exp_ld, 1'b0);
      step();
      mem_ack = 1'b0;
      chk("st_done_req", 64'(mem_req), 64'd0);
      chk("st_ldres_hold", 64'(ldResult_RW), 64'hDEADBEEF);
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

      // Back-to-back load then store, immediate acks
      step();
      drive(1, 1, 0, 1, 32'h100, 32'h0, 5'd9);
      #1 chk("b2b_stall0", 64'(stall_DM), 64'd1);
      step();
      chk("b2b_req1", 64'(mem_req), 64'd1);
      chk("b2b_bub1", 64'(valid_RW), 64'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'h11112222;
      #1 chk("b2b_ack1_stall", 64'(stall_DM), 64'd0);
      exp_ld = 32'h11112222;
      expect_rw(32'h100, 5'd9, 1'b1, 1'b1, exp_ld, 1'b0);
      step();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("b2b_gap_req", 64'(mem_req), 64'd0);
      chk("b2b_ld_valid", 64'(valid_RW), 64'd1);
      drive(1, 0, 1, 0, 32'h104, 32'h3333, 5'd10);
      #1 chk("b2b_stall2", 64'(stall_DM), 64'd1);
      step();
      chk("b2b_req2", 64'(mem_req), 64'd1);
      chk("b2b_we2", 64'(mem_we), 64'd1);
      chk("b2b_wdata2", 64'(mem_wdata), 64'h3333);
      chk("b2b_bub2", 64'(valid_RW), 64'd0);
      mem_ack = 1'b1;
      #1 chk("b2b_ack2_stall", 64'(stall_DM), 64'd0);
      expect_rw(32'h104, 5'd10, 1'b0, 1'b0, exp_ld, 1'b0);
      step();
      mem_ack = 1'b0;
      chk("b2b_done_req", 64'(mem_req), 64'd0);
      chk("b2b_st_valid", 64'(valid_RW), 64'd1);
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

      // Reset while BUSY, then a late ack that must be ignored
      step();
      drive(1, 1, 0, 1, 32'h200, 32'h0, 5'd12);
      step();
      chk("rb_req", 64'(mem_req), 64'd1);
      #1 rst_n = 1'b0;
      #1 chk("rb_req_drop", 64'(mem_req), 64'd0);
      chk("rb_addr", 64'(mem_addr), 64'd0);
      chk("rb_alu", 64'(aluResult_RW), 64'd0);
      chk("rb_ldres", 64'(ldResult_RW), 64'd0);
      chk("rb_rd", 64'(rd_RW), 64'd0);
      chk("rb_isld", 64'(isLd_RW), 64'd0);
      exp_ld = '0;
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      step();
      rst_n = 1'b1;
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      #1 chk("late_ack_stall", 64'(stall_DM), 64'd0);
      step();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("late_ack_req", 64'(mem_req), 64'd0);
      chk("late_ack_ldres", 64'(ldResult_RW), 64'd0);
      chk("late_ack_valid", 64'(valid_RW), 64'd0);

      // Pass-through still works after reset
      drive(1, 0, 0, 0, 32'hCAFE, 32'h0, 5'd31);
      expect_rw(32'hCAFE, 5'd31, 1'b0, 1'b0, exp_ld, 1'b0);
      step();
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

`ifdef DM_TIMEOUT_EN
      // No ack: abort after four BUSY cycles
      step();
      drive(1, 1, 0, 1, 32'h300, 32'h0, 5'd4);
      #1 chk("to_stall0", 64'(stall_DM), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("to_req", 64'(mem_req), 64'd1);
         chk("to_stall", 64'(stall_DM), 64'd1);
      end
      step();
      chk("to_req4", 64'(mem_req), 64'd1);
      chk("to_release", 64'(stall_DM), 64'd0);
      expect_rw(32'h300, 5'd4, 1'b0, 1'b1, exp_ld, 1'b1);
      step();
      chk("to_req_drop", 64'(mem_req), 64'd0);
      chk("to_err", 64'(memErr_RW), 64'd1);
      drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
`endif

      repeat (3) step();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_mem_stage.md
# dm_mem_stage

Memory-access stage controller sitting downstream of the ALU→DM pipeline register and upstream of the register-writeback (RW) stage. It consumes the latched ALU result (used as the address) and the latched second operand (store data), runs a req/ack handshake with the data memory, stalls the front of the pipeline while an access is outstanding, and drives the DM→RW pipeline register. Non-memory instructions pass through in one cycle.

## Interface
- `DATA_W`, default 32: width of address, store data, load data, ALU result.
- `TIMEOUT`, default 16: cycles allowed for `mem_ack` before the access is aborted; only used with `DM_TIMEOUT_EN`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `aluResult_DM`  in  DATA_W  address / pass-through result.
- `op2_DM`  in  DATA_W  store data.
- `rd_DM`  in  5  destination register.
- `isWb_DM`, `isLd_DM`, `isSt_DM`, `valid_DM`  in  1 each  instruction flags.
- `stall_DM`  out  1  hold ALU→DM register and earlier stages.
- `mem_req`, `mem_we`  out  1 each  memory request, write enable.
- `mem_addr`, `mem_wdata`  out  DATA_W  request address, write data.
- `mem_ack`  in  1  single-cycle completion strobe.
- `mem_rdata`  in  DATA_W  load data, valid in the `mem_ack` cycle.
- `ldResult_RW`, `aluResult_RW`  out  DATA_W  DM→RW register.
- `rd_RW`  out  5;  `isWb_RW`, `isLd_RW`, `valid_RW`, `memErr_RW`  out  1 each.

## Operation
- `memop = valid_DM & (isLd_DM | isSt_DM)`; both flags set is treated as a store.
- FSM states IDLE, BUSY. IDLE: `memop` → BUSY, latching address, wdata, `mem_we = isSt_DM`; else stay. BUSY: `mem_ack` → IDLE; else stay.
- `stall_DM = (IDLE & memop) | (BUSY & ~mem_ack)` (combinational).
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` registered; `mem_req` high for every BUSY cycle, outputs stable while `mem_req` high.
- RW register each edge: if `stall_DM` → bubble (`valid_RW=0`, `isWb_RW=0`, `memErr_RW=0`, data fields hold); else load `aluResult_DM`, `rd_DM`, `isWb_DM`, `isLd_DM`, `valid_DM`; `ldResult_RW = mem_rdata` on a load-completing ack, else holds.
- `mem_ack` in IDLE is ignored. Inputs must stay stable while `stall_DM` is high (pipeline guarantee).
- Reset (any time, incl. mid-access): state IDLE, `mem_req=0`, `mem_we=0`, all RW outputs and `mem_addr`/`mem_wdata` = 0; outstanding access dropped.

## Timing
- Non-memory instruction: enters DM at cycle N, visible at RW at N+1, no stall.
- Memory op at DM in cycle N: `stall_DM=1` at N; `mem_req=1` from N+1; ack at cycle N+k (k≥1) → `stall_DM=0` that cycle, RW valid at N+k+1, `mem_req=0` from N+k+1. Minimum latency 2 cycles, one stall cycle.
- Back-to-back memops: next op sees IDLE at N+k+1, `mem_req` drops for exactly one cycle between accesses.

## Configuration
- `DM_TIMEOUT_EN` defined: counter (`$clog2(TIMEOUT+1)` bits) clears on entering BUSY, increments each BUSY cycle without ack; at `TIMEOUT` BUSY cycles without ack → IDLE, `stall_DM=0` that cycle, RW loads with `isWb_RW=0`, `valid_RW=1`, `memErr_RW=1`. Ack on the same cycle wins over timeout.
- Undefined: no counter, BUSY waits indefinitely, `memErr_RW` tied 0.

## Structure
- Shared package `simplerisc_pkg`: `DATA_W` default, register-index width (5), FSM state enum `dm_state_t`.
- No sub-module; optional `dm_timeout_ctr` if the counter is factored out.

## Test plan
- ALU op `aluResult_DM=0x1234`, `rd_DM=3`, `isWb_DM=1` → next cycle `aluResult_RW=0x1234`, `rd_RW=3`, no stall, no `mem_req`.
- Load addr `0x40`, ack 3 cycles after `mem_req`, `mem_rdata=0xDEADBEEF` → `stall_DM` 4 cycles, `ldResult_RW=0xDEADBEEF`, `isLd_RW=1`.
- Store addr `0x80`, `op2_DM=0xA5A5`, ack after 1 cycle → `mem_we=1`, `mem_wdata=0xA5A5`, `isWb_RW` per input, one stall cycle.
- Load, store back-to-back, immediate acks → `mem_req` low exactly one cycle between; RW shows bubble, load, bubble, store.
- `rst_n` low while BUSY → `mem_req=0` immediately; subsequent late ack ignored; all RW outputs 0.
- With `DM_TIMEOUT_EN`, `TIMEOUT=4`, no ack → abort after 4 BUSY cycles, `memErr_RW=1`, `isWb_RW=0`, stall released.
